// File: rtl/rf_operand_stage_if.sv
// Operand-stage bus: ID-stage read addresses, WB-stage write-back, EX-stage operand data.
// The master side is the pipeline control; the slave side is rf_operand_stage.
interface rf_operand_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
) ();
  localparam int unsigned AW = $clog2(NREG);

  logic                 stall;
  logic [NRD*AW-1:0]    rs_adr;
  logic                 wr_en;
  logic [AW-1:0]        wr_adr;
  logic [XLEN-1:0]      wr_data;
  logic [NRD*XLEN-1:0]  rs_data;
  logic                 busy;

  modport master (
    output stall, rs_adr, wr_en, wr_adr, wr_data,
    input  rs_data, busy
  );

  modport slave (
    input  stall, rs_adr, wr_en, wr_adr, wr_data,
    output rs_data, busy
  );
endinterface

// File: rtl/rf_operand_stage.sv
// Register-file operand stage: NRD registered read ports with write-first bypass,
// hard-wired x0, stall hold with write-back refresh, and a post-reset clear walker.
module rf_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned NRD  = 2
) (
  input  logic               clk,
  input  logic               rst_pipe,
  rf_operand_stage_if.slave  bus
);

  typedef enum logic {INIT, RUN} state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic                       busy_q;

  logic [XLEN-1:0]            rf [NREG];
  logic [AW-1:0]              adr_q  [NRD];
  logic [AW-1:0]              rd_adr [NRD];
  logic [XLEN-1:0]            rd_val [NRD];
  logic [NRD-1:0]             hold_hit;
  logic [NRD-1:0][XLEN-1:0]   data_q;
  logic                       wr_hit;

  // State register; busy mirrors the next state so it stays a flop output
  always_ff @(posedge clk) begin
    if (rst_pipe) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == INIT);
    end
  end

  // Walker advances one entry per cycle and leaves INIT after the last entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_hit = (state_q == RUN) && bus.wr_en && (bus.wr_adr != '0);

  // Array storage: no reset, the walker clears it; writes during reset are dropped
  always_ff @(posedge clk) begin
    if (!rst_pipe) begin
      if (state_q == INIT) begin
        rf[cnt_q] <= '0;
      end else if (wr_hit) begin
        rf[bus.wr_adr] <= bus.wr_data;
      end
    end
  end

  // Per-port read value with write-first bypass, and stalled-port refresh match
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_adr[i]   = bus.rs_adr[i*AW +: AW];
      hold_hit[i] = wr_hit && (bus.wr_adr == adr_q[i]);
      if (rd_adr[i] == '0) begin
        rd_val[i] = '0;
      end else if (wr_hit && (bus.wr_adr == rd_adr[i])) begin
        rd_val[i] = bus.wr_data;
      end else begin
        rd_val[i] = rf[rd_adr[i]];
      end
    end
  end

  // ID-to-EX capture registers
  always_ff @(posedge clk) begin
    if (rst_pipe) begin
      for (int i = 0; i < NRD; i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (state_q == INIT) begin
      for (int i = 0; i < NRD; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (!bus.stall) begin
          adr_q[i]  <= rd_adr[i];
          data_q[i] <= rd_val[i];
        end else if (hold_hit[i]) begin
          data_q[i] <= bus.wr_data;
        end
      end
    end
  end

  assign bus.rs_data = data_q;
  assign bus.busy    = busy_q;

endmodule
